// File: rtl/uart_byte_tx_pkg.sv
// Shared types and constants for the UART byte transmitter.
// UART_TX_PARITY_EN (when defined) adds an even-parity bit to each frame.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS     = 8;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Valid/ready byte handshake into the UART transmitter.
// The producer uses the master modport and the transmitter uses the slave modport.
interface uart_byte_tx_if
    import uart_tx_pkg::*;
();

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_byte_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and pulses bit_end
// on the terminal count. The count is cleared whenever run is low.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_end
);

    localparam int            CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_end = run && (cnt_q == TC);

    // Wrapping on the terminal count is what reloads the counter on every bit change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!run || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART transmitter: serialises one accepted byte per 8N1/8N2 frame, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | line at mark, in_ready high, waiting for in_valid
//   START  | driving the start bit (0)
//   DATA   | driving data bits LSB first; bit_cnt wrap ends the phase
//   PARITY | driving the even-parity bit (parity build only)
//   STOP   | driving STOP_BITS stop bits; frame_done in the final clock
module uart_byte_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_byte_tx_if.slave   up,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end

    localparam int              BCW       = $clog2(DATA_BITS);
    localparam logic [BCW-1:0]  LAST_STOP = BCW'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .run     (state_q != IDLE),
        .bit_end (bit_end)
    );

    assign up.in_ready = (state_q == IDLE);
    assign tx          = tx_q;
    assign busy        = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE_LEVEL;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // tx_d always carries the level of the bit that begins at the next edge,
    // so the registered line changes exactly on bit boundaries.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = TX_IDLE_LEVEL;
                if (up.in_valid) begin
                    state_d   = START;
                    shift_d   = up.in_data;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    shift_d   = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                    par_d     = par_q ^ shift_q[0];
`endif
                    if (bit_cnt_d == '0) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q ^ shift_q[0];
`else
                        state_d = STOP;
                        tx_d    = TX_IDLE_LEVEL;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = TX_IDLE_LEVEL;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d    = IDLE;
                        bit_cnt_d  = '0;
                        busy_d     = 1'b0;
                        frame_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                    tx_d = TX_IDLE_LEVEL;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = TX_IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: frame-position reference model checked every
// cycle, plus directed frames with hand-computed line patterns and timing.
module tb_uart_byte_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + 8 + PB + SB;
    localparam int FLEN  = NBITS * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx, busy, frame_done;

    uart_byte_tx_if bif ();

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .up         (bif),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_k is the position inside the current frame (0 = idle,
    // 1..FLEN = cycles since acceptance).
    int         m_k    = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k = 0;
        end else if (m_k == 0) begin
            if (bif.in_valid === 1'b1) begin
                m_byte = bif.in_data;
                m_k    = 1;
            end
        end else if (m_k == FLEN) begin
            m_k = 0;
        end else begin
            m_k++;
        end
    end

    function automatic logic exp_tx(input int k, input logic [7:0] b);
        int idx;
        if (k == 0) return 1'b1;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PB == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_tx",         {31'd0, tx},            {31'd0, exp_tx(m_k, m_byte)});
            chk("model_busy",       {31'd0, busy},          {31'd0, (m_k != 0)});
            chk("model_frame_done", {31'd0, frame_done},    {31'd0, (m_k == FLEN)});
            chk("model_in_ready",   {31'd0, bif.in_ready},  {31'd0, (m_k == 0)});
        end
    end

    logic cap_tx [0:127];
    int   done_cyc;
    int   ready_cyc;

    // mode 0: single byte; 1: hold in_valid, second byte d2; 2: glitch d2/in_valid mid-frame
    task automatic send_cap(input logic [7:0] d, input logic [7:0] d2, input int mode, input int ncyc);
        int t;
        t = 0;
        @(negedge clk);
        while (!bif.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'd0, (t < 100)}, 32'd1);
        bif.in_data  = d;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 1) bif.in_data = d2;
        else bif.in_valid = 1'b0;
        done_cyc  = -1;
        ready_cyc = -1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            cap_tx[c] = tx;
            if (frame_done && done_cyc < 0) done_cyc = c;
            if (bif.in_ready && ready_cyc < 0) ready_cyc = c;
            if (mode == 1 && c == 45) bif.in_valid = 1'b0;
            if (mode == 2 && c == 10) begin
                bif.in_data  = d2;
                bif.in_valid = 1'b1;
            end
            if (mode == 2 && c == 11) bif.in_valid = 1'b0;
        end
    endtask

    // exp bit i is the i-th bit on the line (bit 0 = start bit)
    task automatic check_line(input string name, input int start_c, input int nbits, input logic [15:0] exp);
        logic [15:0] got;
        logic        stable;
        got    = '0;
        stable = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            got[i] = cap_tx[start_c + i*CPB];
            for (int s = 1; s < CPB; s++)
                if (cap_tx[start_c + i*CPB + s] !== got[i]) stable = 1'b0;
        end
        chk({name, "_bits"}, {16'd0, got}, {16'd0, exp});
        chk({name, "_held"}, {31'd0, stable}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        int first_zero;
        logic saw_done;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        chk_on       = 1'b1;

        // 1: reset held for three cycles
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx",         {31'd0, tx},           32'd1);
        chk("rst_in_ready",   {31'd0, bif.in_ready}, 32'd1);
        chk("rst_busy",       {31'd0, busy},         32'd0);
        chk("rst_frame_done", {31'd0, frame_done},   32'd0);

`ifdef UART_TX_PARITY_EN
        // 6: even parity, two stop bits, 0x07
        send_cap(8'h07, 8'h00, 0, 60);
        check_line("t6_line", 1, 12, 16'h0E0E);
        chk("t6_done_cycle",  done_cyc,  32'd48);
        chk("t6_ready_cycle", ready_cyc, 32'd49);
`else
        // 2: single 0x55
        send_cap(8'h55, 8'h00, 0, 50);
        check_line("t2_line", 1, 10, 16'h02AA);
        chk("t2_done_cycle",  done_cyc,  32'd40);
        chk("t2_ready_cycle", ready_cyc, 32'd41);

        // 3: back-to-back 0x00 then 0xFF with in_valid held
        send_cap(8'h00, 8'hFF, 1, 90);
        check_line("t3_first", 1, 10, 16'h0200);
        chk("t3_done_cycle", done_cyc, 32'd40);
        first_zero = -1;
        for (int c = 41; c <= 90; c++)
            if (cap_tx[c] == 1'b0 && first_zero < 0) first_zero = c;
        chk("t3_second_start", first_zero, 32'd42);
        check_line("t3_second", 42, 10, 16'h03FE);

        // 4: reset during data bit 3 of 0xA3, then a clean 0x3C
        send_cap(8'hA3, 8'h00, 0, 18);
        chk("t4_pre_reset_tx", {31'd0, tx}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("t4_async_tx",   {31'd0, tx},   32'd1);
        chk("t4_async_busy", {31'd0, busy}, 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (frame_done) saw_done = 1'b1;
        end
        chk("t4_no_frame_done", {31'd0, saw_done}, 32'd0);
        send_cap(8'h3C, 8'h00, 0, 50);
        check_line("t4_line", 1, 10, 16'h0278);
        chk("t4_done_cycle", done_cyc, 32'd40);

        // 5: in_data/in_valid disturbed mid-frame while sending 0x12
        send_cap(8'h12, 8'hFF, 2, 50);
        check_line("t5_line", 1, 10, 16'h0224);
        chk("t5_done_cycle",  done_cyc,  32'd40);
        chk("t5_ready_cycle", ready_cyc, 32'd41);
`endif

        repeat (4) @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
